// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StReq,
        StDrain,
        StHold,
        StHalted
    } pc_seq_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_next_reg.sv
// 32-bit program counter register with load enable.
module pc_next_reg #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // PC storage; only changes when the sequencer asks for a new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_ADDR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, runs the imem req/ack and decode valid/ready handshakes.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc
);

    pc_seq_state_t state;
    logic [31:0]   redir_pend;
    logic [31:0]   target;
    logic          pc_load;
    logic [31:0]   pc_d;

    assign target    = redirect_target & ALIGN_MASK;
    assign imem_addr = pc;

    pc_next_reg #(
        .RESET_ADDR (RESET_ADDR)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (pc_d),
        .q     (pc)
    );

    // Next-PC mux: hold, sequential +4, redirect target or the parked redirect.
    always_comb begin
        pc_load = 1'b0;
        pc_d    = pc;
        unique case (state)
            StReq: begin
                // A redirect without ack must wait in DRAIN so imem_addr stays stable.
                if (redirect_valid && imem_ack) begin
                    pc_load = 1'b1;
                    pc_d    = target;
                end
            end
            StDrain: begin
                // A redirect arriving with the ack is newer than the parked one.
                if (imem_ack) begin
                    pc_load = 1'b1;
                    pc_d    = redirect_valid ? target : redir_pend;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_d    = target;
                end else if (instr_ready) begin
                    pc_load = 1'b1;
                    pc_d    = pc + INSTR_BYTES;
                end
            end
            StHalted: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_d    = target;
                end
            end
            default: ;
        endcase
    end

    // Sequencing FSM with registered handshake outputs and instruction capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StBoot;
            redir_pend  <= 32'h0;
            instr       <= 32'h0;
            instr_pc    <= RESET_ADDR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            unique case (state)
                StBoot: begin
                    state    <= StReq;
                    imem_req <= 1'b1;
                end
                StReq: begin
                    if (redirect_valid) begin
                        if (!imem_ack) begin
                            redir_pend <= target;
                            state      <= StDrain;
                        end
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        state       <= StHold;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                StDrain: begin
                    if (redirect_valid) begin
                        redir_pend <= target;
                    end
                    if (imem_ack) begin
                        state <= StReq;
                    end
                end
                StHold: begin
                    if (redirect_valid || instr_ready) begin
                        instr_valid <= 1'b0;
                        if (instr_ready && halt) begin
                            state <= StHalted;
                        end else begin
                            state    <= StReq;
                            imem_req <= 1'b1;
                        end
                    end
                end
                StHalted: begin
                    if (resume) begin
                        state    <= StReq;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state       <= StBoot;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner cases, random vs. model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_ack, instr_ready, redirect_valid, halt, resume;
    logic [31:0] redirect_target;
    logic [31:0] imem_rdata;

    logic        req0, valid0, req1, valid1;
    logic [31:0] addr0, instr0, ipc0, pc0;
    logic [31:0] addr1, instr1, ipc1, pc1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Memory returns the inverted address so each word identifies where it came from.
    assign imem_rdata = ~addr0;

    pc_sequencer dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (req0),
        .imem_addr       (addr0),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (valid0),
        .instr           (instr0),
        .instr_pc        (ipc0),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc0)
    );

    pc_sequencer #(
        .RESET_ADDR (32'hFFFF_FFFC)
    ) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (req1),
        .imem_addr       (addr1),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (valid1),
        .instr           (instr1),
        .instr_pc        (ipc1),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        imem_ack        = 1'b0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt            = 1'b0;
        resume          = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid);
        chk({tag, " imem_req"}, {31'h0, req0}, {31'h0, e_req});
        chk({tag, " imem_addr"}, addr0, e_addr);
        chk({tag, " instr_valid"}, {31'h0, valid0}, {31'h0, e_valid});
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        chk("reset imem_req", {31'h0, req0}, 32'h0);
        chk("reset imem_addr", addr0, 32'h0);
        chk("reset instr_valid", {31'h0, valid0}, 32'h0);
        chk("reset instr", instr0, 32'h0);
        chk("reset instr_pc", ipc0, 32'h0);
        chk("reset pc", pc0, 32'h0);
        chk("reset addr wrap dut", addr1, 32'hFFFF_FFFC);
        chk("reset instr_pc wrap dut", ipc1, 32'hFFFF_FFFC);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        ack;
        logic        ready;
        logic        redir;
        logic [31:0] tgt;
        logic        hlt;
        logic        res;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic        chk1;
        logic [31:0] e_addr1;
    } vec_t;

    vec_t tbl[13];

    // Reference model state (transaction view: what is outstanding, what is held).
    bit          m_boot, m_busy, m_held, m_halted, m_parked;
    logic [31:0] m_pc, m_park, m_instr, m_ipc;

    task automatic model_reset();
        m_boot   = 1'b1;
        m_busy   = 1'b0;
        m_held   = 1'b0;
        m_halted = 1'b0;
        m_parked = 1'b0;
        m_pc     = 32'h0;
        m_park   = 32'h0;
        m_instr  = 32'h0;
        m_ipc    = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        logic [31:0] tgt;
        logic        consumed;
        tgt = {redirect_target[31:2], 2'b00};
        if (m_boot) begin
            m_boot = 1'b0;
            m_busy = 1'b1;
        end else if (m_busy && !m_parked) begin
            if (redirect_valid) begin
                if (imem_ack) m_pc = tgt;
                else begin
                    m_parked = 1'b1;
                    m_park   = tgt;
                end
            end else if (imem_ack) begin
                m_instr = ~m_pc;
                m_ipc   = m_pc;
                m_busy  = 1'b0;
                m_held  = 1'b1;
            end
        end else if (m_busy) begin
            if (redirect_valid) m_park = tgt;
            if (imem_ack) begin
                m_pc     = m_park;
                m_parked = 1'b0;
            end
        end else if (m_held) begin
            consumed = instr_ready;
            if (redirect_valid) m_pc = tgt;
            else if (consumed) m_pc = m_pc + 32'd4;
            if (redirect_valid || consumed) begin
                m_held = 1'b0;
                if (consumed && halt) m_halted = 1'b1;
                else m_busy = 1'b1;
            end
        end else if (m_halted) begin
            if (redirect_valid) m_pc = tgt;
            if (resume) begin
                m_halted = 1'b0;
                m_busy   = 1'b1;
            end
        end
    endtask

    initial begin
        //          ack   rdy   redir tgt           hlt   res   req   addr          vld   ipc       chk1  addr1
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,  1'b1, 32'hFFFF_FFFC};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,  1'b1, 32'hFFFF_FFFC};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 32'h0,  1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        1'b1, 32'h4,  1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h8,        1'b0, 32'h0,  1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8,        1'b1, 32'h8,  1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hC,        1'b0, 32'h0,  1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hC,        1'b1, 32'hC,  1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h43,       1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 32'h0,  1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h40,       1'b1, 32'h40, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h44,       1'b0, 32'h0,  1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h44,       1'b0, 32'h0,  1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h44,       1'b0, 32'h0,  1'b0, 32'h0};

        do_reset();

        // Table: sequential fetch, wrap on the second DUT, redirect in HOLD, halt/resume.
        for (int i = 0; i < 13; i++) begin
            imem_ack        = tbl[i].ack;
            instr_ready     = tbl[i].ready;
            redirect_valid  = tbl[i].redir;
            redirect_target = tbl[i].tgt;
            halt            = tbl[i].hlt;
            resume          = tbl[i].res;
            step();
            expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid);
            chk($sformatf("vec%0d pc", i), pc0, tbl[i].e_addr);
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d instr_pc", i), ipc0, tbl[i].e_ipc);
                chk($sformatf("vec%0d instr", i), instr0, ~tbl[i].e_ipc);
            end
            if (tbl[i].chk1) chk($sformatf("vec%0d wrap addr", i), addr1, tbl[i].e_addr1);
        end

        // Wait states: request stays put for three cycles, one capture only.
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("wait%0d", i), 1'b1, 32'h44, 1'b0);
        end
        imem_ack = 1'b1;
        step();
        expect_out("wait ack", 1'b0, 32'h44, 1'b1);
        chk("wait instr", instr0, ~32'h44);
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        step();
        expect_out("wait next", 1'b1, 32'h48, 1'b0);
        instr_ready = 1'b0;

        // Redirect parked in DRAIN, ack two cycles later.
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        expect_out("drain1 a", 1'b1, 32'h48, 1'b0);
        redirect_valid = 1'b0;
        step();
        expect_out("drain1 b", 1'b1, 32'h48, 1'b0);
        imem_ack = 1'b1;
        step();
        expect_out("drain1 ack", 1'b1, 32'h100, 1'b0);
        imem_ack = 1'b0;

        // Two redirects before the ack: the later one wins.
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        step();
        expect_out("drain2 a", 1'b1, 32'h100, 1'b0);
        redirect_target = 32'h200;
        step();
        expect_out("drain2 b", 1'b1, 32'h100, 1'b0);
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        step();
        expect_out("drain2 ack", 1'b1, 32'h200, 1'b0);
        step();
        expect_out("drain2 fetch", 1'b0, 32'h200, 1'b1);
        chk("drain2 instr_pc", ipc0, 32'h200);

        // Halt, redirect while halted, then resume.
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        halt        = 1'b1;
        step();
        expect_out("halt", 1'b0, 32'h204, 1'b0);
        idle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        step();
        expect_out("halted redir", 1'b0, 32'h80, 1'b0);
        idle();
        resume = 1'b1;
        step();
        expect_out("resume", 1'b1, 32'h80, 1'b0);

        // Redirect together with resume.
        idle();
        imem_ack = 1'b1;
        step();
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        halt        = 1'b1;
        step();
        expect_out("halt2", 1'b0, 32'h84, 1'b0);
        idle();
        redirect_valid  = 1'b1;
        redirect_target = 32'hC1;
        resume          = 1'b1;
        step();
        expect_out("redir+resume", 1'b1, 32'hC0, 1'b0);

        // Asynchronous reset in the middle of a request.
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst imem_req", {31'h0, req0}, 32'h0);
        chk("async rst imem_addr", addr0, 32'h0);
        chk("async rst instr_valid", {31'h0, valid0}, 32'h0);
        chk("async rst instr", instr0, 32'h0);
        chk("async rst instr_pc", ipc0, 32'h0);

        // Random stimulus against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            imem_ack        = ($urandom_range(0, 99) < 55);
            instr_ready     = ($urandom_range(0, 99) < 60);
            redirect_valid  = ($urandom_range(0, 99) < 10);
            redirect_target = $urandom;
            halt            = ($urandom_range(0, 99) < 15);
            resume          = ($urandom_range(0, 99) < 30);
            model_clock();
            step();
            expect_out($sformatf("rnd%0d", i), m_busy, m_pc, m_held);
            chk($sformatf("rnd%0d pc", i), pc0, m_pc);
            if (m_held) begin
                chk($sformatf("rnd%0d instr_pc", i), ipc0, m_ipc);
                chk($sformatf("rnd%0d instr", i), instr0, m_instr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
